// File: rtl/aquila_mock_dram.sv
// Behavioural AXI4 slave memory for the Aquila Verilator build: a word array preloaded by
// the harness, INCR bursts, programmable read latency, independent read and write FSMs.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting write beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | latency down-counter running
// R_DATA | rvalid high, presenting beats
module aquila_mock_dram #(
  parameter int          C_S_AXI_ID_WIDTH = 1,
  parameter int          MEM_WORDS        = 65536,
  parameter logic [31:0] BASE_ADDR        = 32'h8000_0000,
  parameter int          READ_LATENCY     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_awid,
  input  logic [31:0]                 S_AXI_awaddr,
  input  logic [7:0]                  S_AXI_awlen,
  input  logic [2:0]                  S_AXI_awsize,
  input  logic [1:0]                  S_AXI_awburst,
  input  logic                        S_AXI_awvalid,
  output logic                        S_AXI_awready,
  input  logic [31:0]                 S_AXI_wdata,
  input  logic [3:0]                  S_AXI_wstrb,
  input  logic                        S_AXI_wlast,
  input  logic                        S_AXI_wvalid,
  output logic                        S_AXI_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_bid,
  output logic [1:0]                  S_AXI_bresp,
  output logic                        S_AXI_bvalid,
  input  logic                        S_AXI_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_arid,
  input  logic [31:0]                 S_AXI_araddr,
  input  logic [7:0]                  S_AXI_arlen,
  input  logic [2:0]                  S_AXI_arsize,
  input  logic [1:0]                  S_AXI_arburst,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_rid,
  output logic [31:0]                 S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rlast,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
  localparam logic [3:0]  LAT_INIT  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  w_state_t    w_state, w_next;
  logic [31:0] wr_addr, wr_word;
  logic [7:0]  wr_len, wr_beat;
  logic        wr_burst_err, wr_err, wr_beat_err, wr_last, wr_err_acc;

  r_state_t    r_state, r_next;
  logic [31:0] rd_addr, fetch_addr, fetch_word, fetch_data;
  logic [7:0]  rd_len, rd_beat;
  logic [3:0]  lat_cnt;
  logic        rd_burst_err, fetch_err;

  assign wr_word     = (wr_addr - BASE_ADDR) >> 2;
  assign wr_beat_err = wr_burst_err || (wr_addr < BASE_ADDR) || (wr_word >= MEM_LIMIT);
  assign wr_last     = (wr_beat == wr_len);
  // A wlast that disagrees with the beat count taints the whole burst, early or missing.
  assign wr_err_acc  = wr_err || wr_beat_err || (S_AXI_wlast != wr_last);

  always_comb begin
    w_next       = w_state;
    S_AXI_wready = 1'b0;
    S_AXI_bvalid = 1'b0;
    case (w_state)
      W_IDLE: if (S_AXI_awvalid && S_AXI_awready) w_next = W_DATA;
      W_DATA: begin
        S_AXI_wready = 1'b1;
        if (S_AXI_wvalid && wr_last) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_bvalid = 1'b1;
        if (S_AXI_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      S_AXI_awready <= 1'b0;
    end else begin
      w_state       <= w_next;
      S_AXI_awready <= (w_next == W_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr      <= '0;
      wr_len       <= '0;
      wr_beat      <= '0;
      wr_burst_err <= 1'b0;
      wr_err       <= 1'b0;
      S_AXI_bid    <= '0;
      S_AXI_bresp  <= 2'b00;
    end else if (w_state == W_IDLE && S_AXI_awvalid && S_AXI_awready) begin
      S_AXI_bid    <= S_AXI_awid;
      wr_addr      <= S_AXI_awaddr;
      wr_len       <= S_AXI_awlen;
      wr_beat      <= '0;
      wr_err       <= 1'b0;
      wr_burst_err <= (S_AXI_awsize != 3'd2) || (S_AXI_awburst != 2'b01);
    end else if (w_state == W_DATA && S_AXI_wvalid) begin
      wr_addr <= wr_addr + 32'd4;
      wr_beat <= wr_beat + 8'd1;
      wr_err  <= wr_err_acc;
      if (wr_last) S_AXI_bresp <= wr_err_acc ? 2'b10 : 2'b00;
    end
  end

  // Array is deliberately left unreset so the harness preload survives.
  always_ff @(posedge clk) begin
    if (w_state == W_DATA && S_AXI_wvalid && !wr_beat_err)
      for (int b = 0; b < 4; b++)
        if (S_AXI_wstrb[b]) mem[wr_word[AW-1:0]][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
  end

  assign fetch_addr = (r_state == R_DATA) ? rd_addr + 32'd4 : rd_addr;
  assign fetch_word = (fetch_addr - BASE_ADDR) >> 2;
  assign fetch_err  = rd_burst_err || (fetch_addr < BASE_ADDR) || (fetch_word >= MEM_LIMIT);
  assign fetch_data = mem[fetch_word[AW-1:0]];

  always_comb begin
    r_next       = r_state;
    S_AXI_rvalid = 1'b0;
    case (r_state)
      R_IDLE: if (S_AXI_arvalid && S_AXI_arready) r_next = R_WAIT;
      R_WAIT: if (lat_cnt == 4'd0) r_next = R_DATA;
      R_DATA: begin
        S_AXI_rvalid = 1'b1;
        if (S_AXI_rready && S_AXI_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      S_AXI_arready <= 1'b0;
    end else begin
      r_state       <= r_next;
      S_AXI_arready <= (r_next == R_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr      <= '0;
      rd_len       <= '0;
      rd_beat      <= '0;
      rd_burst_err <= 1'b0;
      lat_cnt      <= '0;
      S_AXI_rid    <= '0;
      S_AXI_rdata  <= '0;
      S_AXI_rresp  <= 2'b00;
      S_AXI_rlast  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (S_AXI_arvalid && S_AXI_arready) begin
          S_AXI_rid    <= S_AXI_arid;
          rd_addr      <= S_AXI_araddr;
          rd_len       <= S_AXI_arlen;
          rd_beat      <= '0;
          rd_burst_err <= (S_AXI_arsize != 3'd2) || (S_AXI_arburst != 2'b01);
          lat_cnt      <= LAT_INIT;
        end
        R_WAIT: begin
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
          else begin
            S_AXI_rdata <= fetch_err ? 32'd0 : fetch_data;
            S_AXI_rresp <= fetch_err ? 2'b10 : 2'b00;
            S_AXI_rlast <= (rd_len == 8'd0);
          end
        end
        R_DATA: if (S_AXI_rready) begin
          if (S_AXI_rlast) S_AXI_rlast <= 1'b0;
          else begin
            rd_addr     <= fetch_addr;
            rd_beat     <= rd_beat + 8'd1;
            S_AXI_rdata <= fetch_err ? 32'd0 : fetch_data;
            S_AXI_rresp <= fetch_err ? 2'b10 : 2'b00;
            S_AXI_rlast <= (rd_beat + 8'd1 == rd_len);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
